scenario_player: RTL and testbench

SCENARIO_PLAYER -- requirements
Module: scenario_player

---
 rtl/scenario_player.sv | 204 ++++++++++++++++++++
 tb/tb_scenario_player.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scenario_player.sv
// Replays scripted bus commands from a small FIFO, one at a time, with a
// per-command idle delay; read responses are forwarded to the checker side.
module scenario_player #(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          cmdValid,
  output logic          cmdReady,
  input  logic [1:0]    cmdOp,
  input  logic [AW-1:0] cmdAddr,
  input  logic [DW-1:0] cmdData,
  input  logic [7:0]    cmdDelay,
  output logic          busValid,
  input  logic          busReady,
  output logic          busWrite,
  output logic [AW-1:0] busAddr,
  output logic [DW-1:0] busWData,
  input  logic          busRspValid,
  input  logic [DW-1:0] busRData,
  output logic          rdValid,
  output logic [DW-1:0] rdData,
  output logic [AW-1:0] rdAddr,
  output logic          done,
  output logic [15:0]   cmdCount
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = IW + 1;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_NOP   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_DRIVE, S_RESP, S_HALT} state_t;

  logic [1:0]    r_fifo_op    [DEPTH];
  logic [AW-1:0] r_fifo_addr  [DEPTH];
  logic [DW-1:0] r_fifo_data  [DEPTH];
  logic [7:0]    r_fifo_delay [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic [PW-1:0] w_fill;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head_op;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic [7:0]    w_head_delay;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [7:0]    r_delay;
  logic          r_done;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic [AW-1:0] r_rd_addr;
  logic [15:0]   r_count;

  logic          w_exec;
  logic [1:0]    w_exec_op;
  logic          w_retire;
  logic          w_capture;
  logic          w_halt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_fill   = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_fill == PW'(DEPTH));
  assign w_empty  = (w_fill == '0);
  assign cmdReady = rstN & ~w_full & ~r_done;
  assign w_push   = cmdValid & cmdReady;

  assign w_head_op    = r_fifo_op[r_rd_ptr[IW-1:0]];
  assign w_head_addr  = r_fifo_addr[r_rd_ptr[IW-1:0]];
  assign w_head_data  = r_fifo_data[r_rd_ptr[IW-1:0]];
  assign w_head_delay = r_fifo_delay[r_rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr[IW-1:0]]    <= cmdOp;
      r_fifo_addr[r_wr_ptr[IW-1:0]]  <= cmdAddr;
      r_fifo_data[r_wr_ptr[IW-1:0]]  <= cmdData;
      r_fifo_delay[r_wr_ptr[IW-1:0]] <= cmdDelay;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // A command acts either straight out of IDLE (zero delay) or when its
  // delay counter reaches its last cycle.
  assign w_exec    = ((r_state == S_IDLE) && !w_empty && (w_head_delay == 8'd0)) ||
                     ((r_state == S_DELAY) && (r_delay <= 8'd1));
  assign w_exec_op = (r_state == S_IDLE) ? w_head_op : r_op;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_retire    = 1'b0;
    w_capture   = 1'b0;
    w_halt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_delay != 8'd0) w_state_nxt = S_DELAY;
        end
      end
      S_DELAY: w_state_nxt = S_DELAY;
      S_DRIVE: begin
        if (busReady) begin
          if (r_op == OP_WRITE) begin
            w_retire    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (busRspValid) begin
          w_capture   = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_exec) begin
      case (w_exec_op)
        OP_WRITE, OP_READ: w_state_nxt = S_DRIVE;
        OP_NOP: begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_halt      = 1'b1;
          w_state_nxt = S_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_op       <= OP_NOP;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_delay    <= '0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_addr  <= '0;
      r_count    <= '0;
    end else begin
      if (w_pop) begin
        r_op    <= w_head_op;
        r_addr  <= w_head_addr;
        r_wdata <= w_head_data;
        r_delay <= w_head_delay;
      end else if (r_state == S_DELAY) begin
        r_delay <= r_delay - 8'd1;
      end
      r_rd_valid <= w_capture;
      if (w_capture) begin
        r_rd_data <= busRData;
        r_rd_addr <= r_addr;
      end
      if (w_halt)   r_done  <= 1'b1;
      if (w_retire) r_count <= r_count + 16'd1;
    end
  end

  // Bus fields are masked to zero whenever no request is being presented.
  assign busValid = (r_state == S_DRIVE);
  assign busWrite = busValid && (r_op == OP_WRITE);
  assign busAddr  = busValid ? r_addr : '0;
  assign busWData = busWrite ? r_wdata : '0;
  assign rdValid  = r_rd_valid;
  assign rdData   = r_rd_data;
  assign rdAddr   = r_rd_addr;
  assign done     = r_done;
  assign cmdCount = r_count;
endmodule

// File: tb/tb_scenario_player.sv
// Self-checking bench for scenario_player: directed vectors, corner sequences
// and a randomized run checked against a queue-based command model.
`timescale 1ns/1ps
module tb_scenario_player;
  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_NOP  = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          cmdValid;
  logic          cmdReady;
  logic [1:0]    cmdOp;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdData;
  logic [7:0]    cmdDelay;
  logic          busValid;
  logic          busReady;
  logic          busWrite;
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busWData;
  logic          busRspValid;
  logic [DW-1:0] busRData;
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic [AW-1:0] rdAddr;
  logic          done;
  logic [15:0]   cmdCount;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    logic [7:0]  dly;
    logic [31:0] rsp;
    int          exp_lat;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
  } mcmd_t;

  vec_t  tv [6];
  mcmd_t exp_q [$];

  scenario_player #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstN(rstN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdAddr(cmdAddr),
    .cmdData(cmdData), .cmdDelay(cmdDelay),
    .busValid(busValid), .busReady(busReady), .busWrite(busWrite), .busAddr(busAddr),
    .busWData(busWData), .busRspValid(busRspValid), .busRData(busRData),
    .rdValid(rdValid), .rdData(rdData), .rdAddr(rdAddr), .done(done), .cmdCount(cmdCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #990000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmdValid    = 1'b0;
    cmdOp       = 2'd0;
    cmdAddr     = '0;
    cmdData     = '0;
    cmdDelay    = '0;
    busReady    = 1'b0;
    busRspValid = 1'b0;
    busRData    = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busValid"}, 64'(busValid), 64'd0);
    check({tag, "_busWrite"}, 64'(busWrite), 64'd0);
    check({tag, "_busAddr"},  64'(busAddr),  64'd0);
    check({tag, "_busWData"}, 64'(busWData), 64'd0);
    check({tag, "_rdValid"},  64'(rdValid),  64'd0);
    check({tag, "_rdData"},   64'(rdData),   64'd0);
    check({tag, "_rdAddr"},   64'(rdAddr),   64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_cmdCount"}, 64'(cmdCount), 64'd0);
    check({tag, "_cmdReady"}, 64'(cmdReady), 64'd0);
  endtask

  task automatic do_reset(input bit chk);
    idle_inputs();
    rstN = 1'b0;
    #1;
    if (chk) check_reset_vals("rst");
    repeat (2) step();
    rstN = 1'b1;
    #1;
    if (chk) check("rst_ready_after", 64'(cmdReady), 64'd1);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [15:0] a,
                          input logic [31:0] d, input logic [7:0] dl);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdAddr  = a;
    cmdData  = d;
    cmdDelay = dl;
    check("push_ready", 64'(cmdReady), 64'd1);
    step();
    cmdValid = 1'b0;
  endtask

  // Runs one WRITE or READ through the player with an always-ready bus.
  task automatic run_vec(input vec_t v);
    int lat;
    busReady = 1'b1;
    push_cmd(v.op, v.addr, v.data, v.dly);
    lat = 0;
    while (!busValid && lat < 300) begin
      step();
      lat++;
    end
    check("vec_latency", 64'(lat), 64'(v.exp_lat));
    check("vec_busWrite", 64'(busWrite), 64'(v.op == OP_WR));
    check("vec_busAddr", 64'(busAddr), 64'(v.addr));
    if (v.op == OP_WR) check("vec_busWData", 64'(busWData), 64'(v.data));
    step();
    check("vec_busValid_drop", 64'(busValid), 64'd0);
    if (v.op == OP_RD) begin
      busRspValid = 1'b1;
      busRData    = v.rsp;
      step();
      busRspValid = 1'b0;
      busRData    = '0;
      check("vec_rdValid", 64'(rdValid), 64'd1);
      check("vec_rdData", 64'(rdData), 64'(v.rsp));
      check("vec_rdAddr", 64'(rdAddr), 64'(v.addr));
      step();
      check("vec_rdValid_pulse", 64'(rdValid), 64'd0);
    end
    busReady = 1'b0;
    check("vec_cmdCount", 64'(cmdCount), 64'(v.exp_cnt));
  endtask

  initial begin
    int accepted, got, guard, hs, first_t, t0, pushed, bus_left;
    bit rd_out, rsp_sent, exp_rd, prev_stall, hs_now;
    int rsp_wait;
    logic [15:0] exp_rd_addr, prev_addr;
    logic [31:0] exp_rd_data, prev_data;
    logic prev_write;
    mcmd_t m;

    tv[0] = '{OP_WR, 16'h0010, 32'hDEADBEEF, 8'd0,   32'h0,        1,   16'd1};
    tv[1] = '{OP_RD, 16'h0020, 32'h0,        8'd3,   32'h12345678, 4,   16'd2};
    tv[2] = '{OP_WR, 16'hFFFF, 32'hFFFFFFFF, 8'd1,   32'h0,        2,   16'd3};
    tv[3] = '{OP_RD, 16'h0000, 32'h0,        8'd0,   32'hA5A5A5A5, 1,   16'd4};
    tv[4] = '{OP_WR, 16'h8001, 32'h00000001, 8'd255, 32'h0,        256, 16'd5};
    tv[5] = '{OP_RD, 16'h1234, 32'h0,        8'd2,   32'h00000000, 3,   16'd6};

    idle_inputs();
    #2;
    do_reset(1'b1);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // Read with delay 3, bus stalled two cycles, response four cycles later.
    do_reset(1'b0);
    push_cmd(OP_RD, 16'h0020, 32'h0, 8'd3);
    got = 0;
    while (!busValid && got < 50) begin
      step();
      got++;
    end
    check("stall_latency", 64'(got), 64'd4);
    for (int i = 0; i < 2; i++) begin
      check("stall_hold", 64'({busValid, busWrite, busAddr}), 64'({1'b1, 1'b0, 16'h0020}));
      step();
    end
    check("stall_hold_last", 64'({busValid, busAddr}), 64'({1'b1, 16'h0020}));
    busReady = 1'b1;
    step();
    busReady = 1'b0;
    check("resp_bus_idle", 64'({busValid, busAddr}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("resp_wait_rdValid", 64'(rdValid), 64'd0);
    end
    busRspValid = 1'b1;
    busRData    = 32'h12345678;
    step();
    busRspValid = 1'b0;
    busRData    = '0;
    check("resp_rdValid", 64'(rdValid), 64'd1);
    check("resp_rdData", 64'(rdData), 64'h12345678);
    check("resp_rdAddr", 64'(rdAddr), 64'h0020);
    step();
    check("resp_rdValid_pulse", 64'(rdValid), 64'd0);
    check("resp_cmdCount", 64'(cmdCount), 64'd1);

    // Backpressure: FIFO plus working register fill, then drain in order.
    do_reset(1'b0);
    accepted = 0;
    for (int i = 0; i < 16; i++) begin
      cmdValid = 1'b1;
      cmdOp    = OP_WR;
      cmdAddr  = 16'(16'h0100 + accepted);
      cmdData  = 32'hA0000000 | 32'(accepted);
      cmdDelay = 8'd0;
      if (cmdReady) accepted++;
      step();
    end
    cmdValid = 1'b0;
    check("fill_accepted", 64'(accepted), 64'(DEPTH + 1));
    check("fill_ready_low", 64'(cmdReady), 64'd0);
    check("fill_head_held", 64'({busValid, busAddr}), 64'({1'b1, 16'h0100}));
    busReady = 1'b1;
    got = 0;
    guard = 0;
    while (got < DEPTH + 1 && guard < 200) begin
      if (busValid) begin
        check("drain_addr", 64'(busAddr), 64'(16'h0100 + got));
        check("drain_data", 64'(busWData), 64'(32'hA0000000 | 32'(got)));
        got++;
      end
      step();
      guard++;
    end
    busReady = 1'b0;
    check("drain_count", 64'(got), 64'(DEPTH + 1));
    check("drain_cmdCount", 64'(cmdCount), 64'(DEPTH + 1));

    // NOP gap, one write, STOP, trailing write discarded.
    do_reset(1'b0);
    busReady = 1'b1;
    push_cmd(OP_NOP, 16'h0, 32'h0, 8'd5);
    t0 = cyc;
    push_cmd(OP_WR, 16'h0044, 32'h44444444, 8'd0);
    push_cmd(OP_STOP, 16'h0, 32'h0, 8'd0);
    push_cmd(OP_WR, 16'h0055, 32'h55555555, 8'd0);
    hs = 0;
    first_t = 0;
    for (int i = 0; i < 30; i++) begin
      if (busValid) begin
        hs++;
        if (hs == 1) begin
          first_t = cyc;
          check("stop_write_addr", 64'(busAddr), 64'h0044);
        end
      end
      step();
    end
    busReady = 1'b0;
    check("stop_gap", 64'(first_t - t0), 64'd7);
    check("stop_handshakes", 64'(hs), 64'd1);
    check("stop_done", 64'(done), 64'd1);
    check("stop_cmdCount", 64'(cmdCount), 64'd2);
    check("stop_ready", 64'(cmdReady), 64'd0);

    // Reset while waiting for a read response.
    do_reset(1'b0);
    run_vec('{OP_RD, 16'h0066, 32'h0, 8'd0, 32'hCAFEF00D, 1, 16'd1});
    busReady = 1'b1;
    push_cmd(OP_RD, 16'h0077, 32'h0, 8'd0);
    got = 0;
    while (!busValid && got < 20) begin
      step();
      got++;
    end
    check("abort_reached_drive", 64'(busValid), 64'd1);
    step();
    busReady = 1'b0;
    check("abort_in_resp", 64'(busValid), 64'd0);
    rstN = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (2) step();
    rstN = 1'b1;
    #1;
    check("abort_ready", 64'(cmdReady), 64'd1);
    busRspValid = 1'b1;
    busRData    = 32'h99999999;
    step();
    busRspValid = 1'b0;
    check("abort_no_rdValid", 64'(rdValid), 64'd0);
    check("abort_rdData", 64'(rdData), 64'd0);
    check("abort_cmdCount", 64'(cmdCount), 64'd0);
    check("abort_ready_clk", 64'(cmdReady), 64'd1);

    // Randomized traffic against the ordered-command model.
    do_reset(1'b0);
    exp_q.delete();
    pushed = 0; rd_out = 0; rsp_sent = 0; exp_rd = 0; prev_stall = 0; rsp_wait = 0;
    exp_rd_addr = '0; exp_rd_data = '0; prev_addr = '0; prev_data = '0; prev_write = 0;
    for (int i = 0; i < 2600; i++) begin
      check("rnd_rdValid", 64'(rdValid), 64'(exp_rd));
      if (exp_rd && rdValid) begin
        check("rnd_rdData", 64'(rdData), 64'(exp_rd_data));
        check("rnd_rdAddr", 64'(rdAddr), 64'(exp_rd_addr));
      end
      if (exp_rd) begin
        exp_rd = 0;
        rd_out = 0;
      end
      if (!busValid) check("rnd_idle_zero", 64'({busAddr, busWData}), 64'd0);
      if (prev_stall)
        check("rnd_stable", 64'({busValid, busWrite, busAddr, busWData}),
              64'({1'b1, prev_write, prev_addr, prev_data}));
      if (busValid) check("rnd_single_outstanding", 64'(rd_out), 64'd0);
      busReady   = ($urandom_range(0, 2) != 0);
      prev_stall = busValid && !busReady;
      prev_write = busWrite;
      prev_addr  = busAddr;
      prev_data  = busWData;
      hs_now     = 0;
      if (busValid && busReady) begin
        hs_now = 1;
        while (exp_q.size() > 0 && exp_q[0].op == OP_NOP) m = exp_q.pop_front();
        check("rnd_hs_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          m = exp_q.pop_front();
          check("rnd_hs_write", 64'(busWrite), 64'(m.op == OP_WR));
          check("rnd_hs_addr", 64'(busAddr), 64'(m.addr));
          if (m.op == OP_WR) check("rnd_hs_data", 64'(busWData), 64'(m.data));
          if (m.op == OP_RD) begin
            rd_out      = 1;
            rsp_sent    = 0;
            rsp_wait    = $urandom_range(1, 4);
            exp_rd_addr = m.addr;
          end
        end
      end
      busRspValid = 1'b0;
      busRData    = $urandom;
      if (rd_out && !rsp_sent && !hs_now) begin
        if (rsp_wait <= 1) begin
          busRspValid = 1'b1;
          exp_rd_data = busRData;
          rsp_sent    = 1;
          exp_rd      = 1;
        end else begin
          rsp_wait--;
        end
      end else if (!rd_out && $urandom_range(0, 7) == 0) begin
        busRspValid = 1'b1;
      end
      if (i < 2000 && $urandom_range(0, 1) == 1) begin
        cmdValid = 1'b1;
        cmdOp    = 2'($urandom_range(0, 2));
        cmdAddr  = 16'($urandom);
        cmdData  = $urandom;
        cmdDelay = 8'($urandom_range(0, 3));
        if (cmdReady) begin
          exp_q.push_back('{cmdOp, cmdAddr, cmdData});
          pushed++;
        end
      end else begin
        cmdValid = 1'b0;
      end
      step();
    end
    idle_inputs();
    bus_left = 0;
    while (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      if (m.op != OP_NOP) bus_left++;
    end
    check("rnd_all_bus_done", 64'(bus_left), 64'd0);
    check("rnd_no_read_pending", 64'(rd_out), 64'd0);
    check("rnd_cmdCount", 64'(cmdCount), 64'(16'(pushed)));

    // Counter wrap after 65537 zero-delay NOPs.
    do_reset(1'b0);
    accepted = 0;
    guard = 0;
    cmdOp = OP_NOP;
    cmdDelay = 8'd0;
    while (accepted < 65537 && guard < 70000) begin
      cmdValid = 1'b1;
      if (cmdReady) accepted++;
      step();
      guard++;
    end
    cmdValid = 1'b0;
    repeat (4) step();
    check("wrap_accepted", 64'(accepted), 64'd65537);
    check("wrap_cmdCount", 64'(cmdCount), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
